// File: rtl/sram_arbiter.sv
// Round-robin arbiter folding N SRAM requesters onto one single-port macro, with read-return routing.
// Grant is combinational (zero latency); read data returns RdLatency cycles after the accepted read.
// No backpressure: the macro accepts every request, and losing requesters simply hold req until granted.
module sram_arbiter #(
  parameter int N         = 2,
  parameter int SramAw    = 12,
  parameter int SramDw    = 32,
  parameter int RdLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          req_i,
  output logic [N-1:0]          gnt_o,
  input  logic [N-1:0]          we_i,
  input  logic [N*SramAw-1:0]   addr_i,
  input  logic [N*SramDw-1:0]   wdata_i,
  input  logic [N*SramDw-1:0]   wmask_i,
  output logic [N-1:0]          rvalid_o,
  output logic [SramDw-1:0]     rdata_o,
  output logic [1:0]            rerror_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [SramAw-1:0]     addr_o,
  output logic [SramDw-1:0]     wdata_o,
  output logic [SramDw-1:0]     wmask_o,
  input  logic [SramDw-1:0]     rdata_i,
  input  logic [1:0]            rerror_i
);

  localparam int IdW = $clog2(N);

  logic [IdW-1:0]       ptr;
  logic [IdW-1:0]       win;
  logic                 win_vld;
  logic [RdLatency-1:0] tag_vld;
  logic [IdW-1:0]       tag_id [RdLatency];

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win     = idx[IdW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr     <= '0;
      tag_vld <= '0;
      for (int s = 0; s < RdLatency; s++) tag_id[s] <= '0;
    end else begin
      tag_vld[0] <= win_vld & ~we_i[win];
      tag_id[0]  <= win;
      for (int s = 1; s < RdLatency; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      if (win_vld) ptr <= (win == IdW'(N - 1)) ? '0 : win + IdW'(1);
    end
  end

  // Everything is held at zero during reset, including the read-return path.
  always_comb begin
    gnt_o    = '0;
    req_o    = 1'b0;
    we_o     = 1'b0;
    addr_o   = '0;
    wdata_o  = '0;
    wmask_o  = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    rerror_o = '0;
    if (!rst_i) begin
      if (win_vld) begin
        gnt_o[win] = 1'b1;
        req_o      = 1'b1;
        we_o       = we_i[win];
        addr_o     = addr_i[win*SramAw +: SramAw];
        wdata_o    = wdata_i[win*SramDw +: SramDw];
        wmask_o    = wmask_i[win*SramDw +: SramDw];
      end
      if (tag_vld[RdLatency-1]) begin
        rvalid_o[tag_id[RdLatency-1]] = 1'b1;
        rdata_o  = rdata_i;
        rerror_o = rerror_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: three instances cover N=2/RdLatency=1, N=3/RdLatency=3 and N=2/RdLatency=2.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Instance A: N=2, RdLatency=1
  logic        a_rst = 1'b1;
  logic [1:0]  a_req = '0, a_we = '0, a_gnt, a_rvalid;
  logic [23:0] a_addr = '0;
  logic [63:0] a_wdata = '0, a_wmask = '0;
  logic [31:0] a_rdata_o, a_wdata_o, a_wmask_o, a_rdata_i = '0;
  logic [1:0]  a_rerr_o, a_rerr_i = '0;
  logic        a_req_o, a_we_o;
  logic [11:0] a_addr_o;

  sram_arbiter #(.N(2), .SramAw(12), .SramDw(32), .RdLatency(1)) dut_a (
    .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we),
    .addr_i(a_addr), .wdata_i(a_wdata), .wmask_i(a_wmask), .rvalid_o(a_rvalid),
    .rdata_o(a_rdata_o), .rerror_o(a_rerr_o), .req_o(a_req_o), .we_o(a_we_o),
    .addr_o(a_addr_o), .wdata_o(a_wdata_o), .wmask_o(a_wmask_o),
    .rdata_i(a_rdata_i), .rerror_i(a_rerr_i));

  // Instance B: N=3, RdLatency=3
  logic        b_rst = 1'b1;
  logic [2:0]  b_req = '0, b_we = '0, b_gnt, b_rvalid;
  logic [35:0] b_addr = '0;
  logic [95:0] b_wdata = '0, b_wmask = '0;
  logic [31:0] b_rdata_o, b_wdata_o, b_wmask_o, b_rdata_i = '0;
  logic [1:0]  b_rerr_o, b_rerr_i = '0;
  logic        b_req_o, b_we_o;
  logic [11:0] b_addr_o;

  sram_arbiter #(.N(3), .SramAw(12), .SramDw(32), .RdLatency(3)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we),
    .addr_i(b_addr), .wdata_i(b_wdata), .wmask_i(b_wmask), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata_o), .rerror_o(b_rerr_o), .req_o(b_req_o), .we_o(b_we_o),
    .addr_o(b_addr_o), .wdata_o(b_wdata_o), .wmask_o(b_wmask_o),
    .rdata_i(b_rdata_i), .rerror_i(b_rerr_i));

  // Instance C: N=2, RdLatency=2
  logic        c_rst = 1'b1;
  logic [1:0]  c_req = '0, c_we = '0, c_gnt, c_rvalid;
  logic [23:0] c_addr = '0;
  logic [63:0] c_wdata = '0, c_wmask = '0;
  logic [31:0] c_rdata_o, c_wdata_o, c_wmask_o, c_rdata_i = '0;
  logic [1:0]  c_rerr_o, c_rerr_i = '0;
  logic        c_req_o, c_we_o;
  logic [11:0] c_addr_o;

  sram_arbiter #(.N(2), .SramAw(12), .SramDw(32), .RdLatency(2)) dut_c (
    .clk_i(clk), .rst_i(c_rst), .req_i(c_req), .gnt_o(c_gnt), .we_i(c_we),
    .addr_i(c_addr), .wdata_i(c_wdata), .wmask_i(c_wmask), .rvalid_o(c_rvalid),
    .rdata_o(c_rdata_o), .rerror_o(c_rerr_o), .req_o(c_req_o), .we_o(c_we_o),
    .addr_o(c_addr_o), .wdata_o(c_wdata_o), .wmask_o(c_wmask_o),
    .rdata_i(c_rdata_i), .rerror_i(c_rerr_i));

  // Inputs change on negedge; checks run 1 time unit later, well before the next posedge.
  task automatic reset_all();
    @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_req = '0; b_req = '0; c_req = '0;
    a_we = '0; b_we = '0; c_we = '0;
    a_rdata_i = '0; b_rdata_i = '0; c_rdata_i = '0;
    a_rerr_i = '0; b_rerr_i = '0; c_rerr_i = '0;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_rst = 1'b1; a_req = 2'b11; a_we = 2'b11; a_addr = 24'h123456;
    a_wdata = {64{1'b1}}; a_wmask = {64{1'b1}}; a_rdata_i = 32'hFFFFFFFF; a_rerr_i = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if ({a_gnt, a_rvalid, a_req_o, a_we_o, a_addr_o, a_wdata_o, a_wmask_o, a_rdata_o, a_rerr_o} !== '0)
      $display("FAIL reset_outputs: gnt=%b rvalid=%b req=%b we=%b addr=%h wdata=%h rdata=%h rerr=%b, all must be 0",
               a_gnt, a_rvalid, a_req_o, a_we_o, a_addr_o, a_wdata_o, a_rdata_o, a_rerr_o);
    else passes++;
    checks++;
    if (dut_a.ptr !== 1'b0) $display("FAIL reset_ptr: got %0d want 0", dut_a.ptr); else passes++;
    @(negedge clk);
    a_rst = 1'b0; a_req = 2'b10; a_we = 2'b00; a_addr = '0; a_addr[12 +: 12] = 12'h010;
    a_rdata_i = '0; a_rerr_i = '0;
    #1;
    checks++;
    if (a_gnt !== 2'b10 || a_addr_o !== 12'h010)
      $display("FAIL reset_first_read: gnt=%b addr=%h want gnt=10 addr=010", a_gnt, a_addr_o);
    else passes++;
    @(negedge clk);
    a_req = 2'b00; a_rdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (a_rvalid !== 2'b10 || a_rdata_o !== 32'hDEADBEEF)
      $display("FAIL reset_first_return: rvalid=%b rdata=%h want 10 deadbeef", a_rvalid, a_rdata_o);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic       exp_ptr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset_all();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req = 2'b11; a_we = 2'b00;
      #1;
      checks++;
      if (a_gnt !== exp_gnt[i]) $display("FAIL rr_gnt%0d: got %b want %b", i, a_gnt, exp_gnt[i]);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (dut_a.ptr !== exp_ptr[i]) $display("FAIL rr_ptr%0d: got %0d want %0d", i, dut_a.ptr, exp_ptr[i]);
      else passes++;
    end
  endtask

  task automatic test_write_read();
    reset_all();
    @(negedge clk);
    a_req = 2'b01; a_we = 2'b01; a_addr = '0; a_addr[0 +: 12] = 12'h004;
    a_wdata = '0; a_wdata[0 +: 32] = 32'hA5A5A5A5; a_wmask = '0; a_wmask[0 +: 32] = 32'hFFFFFFFF;
    #1;
    checks++;
    if (a_gnt !== 2'b01 || a_req_o !== 1'b1 || a_we_o !== 1'b1 || a_addr_o !== 12'h004 ||
        a_wdata_o !== 32'hA5A5A5A5 || a_wmask_o !== 32'hFFFFFFFF)
      $display("FAIL wr_issue: gnt=%b req=%b we=%b addr=%h wdata=%h wmask=%h want 01 1 1 004 a5a5a5a5 ffffffff",
               a_gnt, a_req_o, a_we_o, a_addr_o, a_wdata_o, a_wmask_o);
    else passes++;
    @(negedge clk);
    a_req = 2'b10; a_we = 2'b00; a_addr[12 +: 12] = 12'h004;
    #1;
    checks++;
    if (a_gnt !== 2'b10 || a_we_o !== 1'b0 || a_addr_o !== 12'h004 || a_rvalid !== 2'b00 || a_wdata_o !== 32'h0)
      $display("FAIL rd_issue: gnt=%b we=%b addr=%h rvalid=%b wdata=%h want 10 0 004 00 0",
               a_gnt, a_we_o, a_addr_o, a_rvalid, a_wdata_o);
    else passes++;
    @(negedge clk);
    a_req = 2'b00; a_rdata_i = 32'hA5A5A5A5;
    #1;
    checks++;
    if (a_rvalid !== 2'b10 || a_rdata_o !== 32'hA5A5A5A5)
      $display("FAIL rd_return: rvalid=%b rdata=%h want 10 a5a5a5a5", a_rvalid, a_rdata_o);
    else passes++;
    a_rdata_i = '0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_gnt [9] = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b010};
    logic [2:0]  exp_rv  [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [2:0]  req_v   [9] = '{3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111};
    logic [2:0]  we_v    [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111};
    logic [31:0] rd_v    [9] = '{0, 0, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0};
    logic [1:0]  re_v    [9] = '{2'b10, 0, 0, 0, 2'b10, 0, 2'b10, 0, 0};
    logic [31:0] exp_rd;
    logic [1:0]  exp_re;
    reset_all();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b_req = req_v[i]; b_we = we_v[i]; b_rdata_i = rd_v[i]; b_rerr_i = re_v[i];
      exp_rd = (exp_rv[i] != 3'b000) ? rd_v[i] : 32'h0;
      exp_re = (exp_rv[i] != 3'b000) ? re_v[i] : 2'b00;
      #1;
      checks++;
      if (b_gnt !== exp_gnt[i] || b_rvalid !== exp_rv[i] || b_rdata_o !== exp_rd || b_rerr_o !== exp_re)
        $display("FAIL b2b_cyc%0d: gnt=%b rvalid=%b rdata=%h rerr=%b want %b %b %h %b",
                 i, b_gnt, b_rvalid, b_rdata_o, b_rerr_o, exp_gnt[i], exp_rv[i], exp_rd, exp_re);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    reset_all();
    @(negedge clk);
    c_req = 2'b01; c_we = 2'b00;
    @(negedge clk);
    c_rst = 1'b1; c_req = 2'b00;
    @(negedge clk);
    c_rst = 1'b0; c_rdata_i = 32'hBEEFCAFE;
    #1;
    checks++;
    if (c_rvalid !== 2'b00 || c_rdata_o !== 32'h0)
      $display("FAIL midrst_rvalid: rvalid=%b rdata=%h want 00 0", c_rvalid, c_rdata_o);
    else passes++;
    checks++;
    if (dut_c.ptr !== 1'b0) $display("FAIL midrst_ptr: got %0d want 0", dut_c.ptr); else passes++;
    @(negedge clk);
    #1;
    checks++;
    if (c_rvalid !== 2'b00) $display("FAIL midrst_late: rvalid=%b want 00", c_rvalid); else passes++;
    c_rdata_i = '0;
  endtask

  task automatic test_idle();
    reset_all();
    @(negedge clk);
    a_req = 2'b01; a_we = 2'b01;
    @(negedge clk);
    a_req = 2'b00; a_we = 2'b11; a_addr = 24'hABCDEF; a_wdata = {64{1'b1}}; a_wmask = {64{1'b1}};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (a_req_o !== 1'b0 || a_gnt !== 2'b00 || a_addr_o !== 12'h0 || a_we_o !== 1'b0 ||
          a_wdata_o !== 32'h0 || dut_a.ptr !== 1'b1)
        $display("FAIL idle_cyc%0d: req=%b gnt=%b addr=%h we=%b wdata=%h ptr=%0d want 0 00 000 0 0 1",
                 i, a_req_o, a_gnt, a_addr_o, a_we_o, a_wdata_o, dut_a.ptr);
      else passes++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_back_to_back();
    test_mid_reset();
    test_idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sits directly downstream of one or more TL-UL SRAM adapters and directly upstream of a single-port SRAM macro.
- Arbitrates N SRAM-style requesters (req/gnt/we/addr/wdata/wmask) onto one fixed-latency SRAM port.
- Grants in the same cycle as the request, using round-robin priority.
- Routes read-return data (rvalid/rdata/rerror) to the requester that issued each read, using an internal tag pipeline that matches the macro read latency.

Parameters:
- N, 2, number of requesters; N >= 2.
- SramAw, 12, SRAM word address width.
- SramDw, 32, SRAM data width.
- RdLatency, 1, cycles from accepted read to rdata_i valid at the macro; RdLatency >= 1.
- IdW, $clog2(N), requester index width (derived localparam, not overridable).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- req_i  input  N  per-requester request.
- gnt_o  output  N  per-requester grant; one-hot or zero.
- we_i  input  N  per-requester write enable.
- addr_i  input  N*SramAw  per-requester address; requester k occupies bits [k*SramAw +: SramAw].
- wdata_i  input  N*SramDw  per-requester write data.
- wmask_i  input  N*SramDw  per-requester bit write mask.
- rvalid_o  output  N  per-requester read-data valid; at most one bit set.
- rdata_o  output  SramDw  read data, shared by all requesters; qualified by rvalid_o.
- rerror_o  output  2  read error, shared; qualified by rvalid_o; [1] uncorrectable, [0] correctable.
- req_o  output  1  request to the SRAM macro.
- we_o  output  1  write enable to the macro.
- addr_o  output  SramAw  address to the macro.
- wdata_o  output  SramDw  write data to the macro.
- wmask_o  output  SramDw  write mask to the macro.
- rdata_i  input  SramDw  read data from the macro; valid exactly RdLatency cycles after a read is accepted.
- rerror_i  input  2  read error from the macro; same timing as rdata_i.

Behaviour:
- All state updates on posedge clk_i.
- Reset (rst_i=1): priority pointer resets to 0; every tag-pipeline stage resets to invalid.
- While in reset, all of these outputs are forced to 0: gnt_o, rvalid_o, req_o, we_o, addr_o, wdata_o, wmask_o, rdata_o, rerror_o.
- Arbitration is combinational and zero-latency:
  - Winner w = first k with req_i[k]=1, scanning k = ptr, ptr+1, ..., wrapping modulo N.
  - gnt_o[w]=1; all other gnt_o bits are 0. No requests means gnt_o=0.
- Macro outputs:
  - req_o = |req_i.
  - we_o, addr_o, wdata_o and wmask_o are muxed from w.
  - When req_o=0, we_o, addr_o, wdata_o and wmask_o are all 0.
- The macro never stalls. Every cycle with req_o=1 is an accepted access.
- Pointer update: on any cycle with req_o=1, ptr <= (w+1) mod N. Otherwise ptr holds. Wrap from N-1 returns to 0.
- A requester that holds req_i high while ungranted sees no side effects. It is served within N cycles (starvation bound).
- Tag pipeline: shift register, RdLatency stages of {valid, id}.
  - Stage 0 is loaded with {req_o & ~we_o, w} each cycle.
  - Each stage shifts by one every cycle.
- Read return: when the last stage is valid with id=k:
  - rvalid_o[k]=1.
  - rdata_o = rdata_i and rerror_o = rerror_i, passed through combinationally.
- When the last stage is invalid: rvalid_o=0, rdata_o=0, rerror_o=0.
- Writes never produce rvalid_o.
- Back-to-back reads from different requesters are returned in issue order, one per cycle, with no bubbles.
- A new grant and a read return in the same cycle are independent; both happen.
- Reset mid-operation clears in-flight tags. Reads issued before the reset never produce rvalid_o, even if the macro returns data.
- An X or toggling req_i from a non-winning requester does not affect the winner's outputs.

Test Plan:
- Reset: after rst_i=1 for 2 cycles, all outputs are 0. With RdLatency=1, after reset deasserts, a read by req 1 at addr 0x010 gives gnt_o=2'b10 and addr_o=0x010. One cycle later rvalid_o=2'b10 and rdata_o equals the macro data 0xDEADBEEF.
- Round-robin: req_i=2'b11 held for 4 cycles from reset. Grants sequence 01, 10, 01, 10. ptr alternates 1, 0, 1, 0.
- Write/read mix: cycle 0 req 0 writes 0xA5A5A5A5 to 0x004 with wmask all-ones; cycle 1 req 1 reads 0x004. Expect we_o=1 then 0, no rvalid for the write, and rvalid_o=2'b10 with rdata_o=0xA5A5A5A5 at cycle 2.
- RdLatency=3, N=3: reads by reqs 2, 0, 1 in consecutive cycles. Expect rvalid_o = 3'b100, 3'b001, 3'b010 at cycles 3, 4, 5, with matching rdata. rerror_i=2'b10 on the second return yields rerror_o=2'b10 only while rvalid_o=3'b001.
- Reset mid-flight: with RdLatency=2, issue a read at cycle 0 and assert rst_i at cycle 1. rvalid_o stays 0 at cycle 2 and afterwards, and ptr=0.
- Idle: req_i=0 for 5 cycles. req_o=0, gnt_o=0 and addr_o=0 throughout, and ptr is unchanged.
